// File: rtl/dff_pkg.sv
// Shared constants and the width helper for the elastic register pipeline.
package dff_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: data register with load enable plus its valid bit.
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             v,
    output logic [WIDTH-1:0] data
);

    logic             v_d, v_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Loading a bubble clears v but leaves the data register untouched.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d    = 1'b0;
            data_d = RESET_VAL;
        end else if (load) begin
            v_d = in_v;
            if (in_v) begin
                data_d = in_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= RESET_VAL;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v    = v_q;
    assign data = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready flow control,
// synchronous flush and a registered occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      flush,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] go;
    logic [DEPTH-1:0] ld_v;
    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] ld_d [DEPTH];

    logic          in_fire, out_fire;
    logic [CW-1:0] count_d, count_q;

    // Stage i may load unless it and every stage after it are full while
    // the output is stalled; this is the only out_ready -> in_ready path.
    always_comb begin : ready_chain
        logic tail_full;
        tail_full = 1'b1;
        go        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tail_full = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                tail_full = tail_full & v[j];
            end
            go[i] = out_ready | ~tail_full;
        end
    end

    always_comb begin
        ld_v[0] = in_valid;
        ld_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            ld_v[i] = v[i-1];
            ld_d[i] = data[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (go[g]),
            .in_v  (ld_v[g]),
            .in_d  (ld_d[g]),
            .v     (v[g]),
            .data  (data[g])
        );
    end

    assign in_fire  = in_valid & go[0];
    assign out_fire = v[DEPTH-1] & out_ready;

    // Count tracks accepted minus emitted beats, so it always equals popcount(v).
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_fire) - CW'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_ready  = go[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign count     = count_q;

endmodule
